// File: rtl/debounce_pulse.sv
// debounce_pulse: synchronizes and debounces a raw button, emitting rise/fall pulses and a press counter.
module debounce_pulse #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn,
  output logic       d_out,
  output logic       rise,
  output logic       fall,
  output logic       busy,
  output logic [7:0] press_count
);
  typedef enum logic [1:0] {IDLE_LOW, CHK_HIGH, IDLE_HIGH, CHK_LOW} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  state_t           state_q, state_d;
  logic             s1_q, s2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             d_out_q, d_out_d, rise_q, rise_d, fall_q, fall_d, busy_q, busy_d;
  logic [7:0]       press_q, press_d;
  // Entering a CHK state already counts the first stable sample, hence cnt starts at 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_out_d = d_out_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    press_d = press_q;
    case (state_q)
      IDLE_LOW: if (s2_q) begin
        state_d = CHK_HIGH;
        cnt_d   = ONE;
      end
      CHK_HIGH: if (!s2_q) begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
      end else if (cnt_q == LAST) begin
        state_d = IDLE_HIGH;
        cnt_d   = '0;
        d_out_d = 1'b1;
        rise_d  = 1'b1;
        press_d = press_q + 8'd1;
      end else cnt_d = cnt_q + ONE;
      IDLE_HIGH: if (!s2_q) begin
        state_d = CHK_LOW;
        cnt_d   = ONE;
      end
      CHK_LOW: if (s2_q) begin
        state_d = IDLE_HIGH;
        cnt_d   = '0;
      end else if (cnt_q == LAST) begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
        d_out_d = 1'b0;
        fall_d  = 1'b1;
      end else cnt_d = cnt_q + ONE;
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == CHK_HIGH) || (state_d == CHK_LOW);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      d_out_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
      press_q <= '0;
    end else begin
      s1_q    <= btn;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_out_q <= d_out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
      press_q <= press_d;
    end
  end
  assign d_out       = d_out_q;
  assign rise        = rise_q;
  assign fall        = fall_q;
  assign busy        = busy_q;
  assign press_count = press_q;
endmodule

// File: tb/tb_debounce_pulse.sv
// tb_debounce_pulse: directed stimulus with a pulse scoreboard for debounce_pulse.
`timescale 1ns/100ps
module tb_debounce_pulse;
  logic       clk, reset, btn;
  logic       d_out, rise, fall, busy;
  logic [7:0] press_count;
  int         tests = 0, fails = 0, cyc = 0;
  typedef struct {logic kind; logic [7:0] cnt; int cyc;} ev_t;
  ev_t        q[$];

  debounce_pulse #(.STABLE_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .btn(btn), .d_out(d_out), .rise(rise),
    .fall(fall), .busy(busy), .press_count(press_count)
  );

  initial clk = 1'b0;
  always #3 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive btn at a negedge; an accepted change pulses on the 6th following edge.
  task automatic drive(input logic v, input logic push, input logic [7:0] pc);
    ev_t e;
    btn = v;
    if (push) begin
      e.kind = v; e.cnt = pc; e.cyc = cyc + 6;
      q.push_back(e);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {d_out, rise, fall, busy, press_count}, 0);
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (!reset && (rise || fall)) begin
      chk("rise_fall_excl", rise & fall, 0);
      if (q.size() == 0) chk("unexpected_pulse", {rise, fall}, 0);
      else begin
        e = q.pop_front();
        chk("pulse_kind", rise, e.kind);
        chk("pulse_dout", d_out, e.kind);
        chk("pulse_press", press_count, e.cnt);
        chk("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    btn = 1'b0;
    reset = 1'b1;
    #1 chk_zero("por_reset");
    tick(2);
    reset = 1'b0;
    tick(2);
    chk_zero("after_reset");
    // clean press: busy for exactly three cycles, then rise
    drive(1'b1, 1'b1, 8'd1);
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      chk("busy_window", busy, (k >= 3 && k <= 5) ? 1 : 0);
      chk("dout_latency", d_out, (k == 6) ? 1 : 0);
    end
    tick(20);
    chk("press_after_clean", press_count, 1);
    drive(1'b0, 1'b1, 8'd1);
    tick(20);
    chk("dout_released", d_out, 0);
    chk("press_after_release", press_count, 1);
    // short glitch must be rejected
    drive(1'b1, 1'b0, 8'd0);
    tick(2);
    drive(1'b0, 1'b0, 8'd0);
    tick(20);
    chk("glitch_dout", d_out, 0);
    chk("glitch_press", press_count, 1);
    // bouncing edge: only the final 0->1 qualifies
    drive(1'b1, 1'b0, 8'd0); tick(1);
    drive(1'b0, 1'b0, 8'd0); tick(1);
    drive(1'b1, 1'b0, 8'd0); tick(1);
    drive(1'b0, 1'b0, 8'd0); tick(1);
    drive(1'b1, 1'b1, 8'd2);
    tick(20);
    chk("bounce_dout", d_out, 1);
    chk("bounce_press", press_count, 2);
    // asynchronous reset between edges, btn still high -> fresh qualification
    @(posedge clk);
    #1 reset = 1'b1;
    #0.5 chk_zero("async_reset");
    begin
      ev_t e;
      e.kind = 1'b1; e.cnt = 8'd1; e.cyc = cyc + 6;
      q.push_back(e);
    end
    #0.5 reset = 1'b0;
    tick(20);
    chk("reset_requal_press", press_count, 1);
    drive(1'b0, 1'b1, 8'd1);
    tick(20);
    // reset mid-qualification discards it
    drive(1'b1, 1'b0, 8'd0);
    tick(4);
    chk("mid_chk_busy", busy, 1);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      chk_zero("held_reset");
    end
    reset = 1'b0;
    drive(1'b1, 1'b1, 8'd1);
    tick(10);
    chk("post_reset_press", press_count, 1);
    drive(1'b0, 1'b1, 8'd1);
    tick(10);
    for (int i = 2; i <= 256; i++) begin
      drive(1'b1, 1'b1, 8'(i));
      tick(10);
      drive(1'b0, 1'b1, 8'(i));
      tick(10);
    end
    chk("press_wrap", press_count, 0);
    chk("scoreboard_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
